// File: rtl/mode_input_ctrl_pkg.sv
// mode_input_ctrl_pkg
// Shared definitions for the operator-input front end:
//   regime_e : mode encodings, shared with the control path
//   state_e  : request FSM states
//   BTN_*    : bit positions of the buttons in the packed button vector
//   mode_from_press : same-cycle mode press priority (update > cnt > elist)
package mode_input_ctrl_pkg;

  typedef enum logic [1:0] {
    REGIME_OFF    = 2'd0,
    REGIME_ELIST  = 2'd1,
    REGIME_CNT    = 2'd2,
    REGIME_UPDATE = 2'd3
  } regime_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned BTN_ELIST  = 0;
  localparam int unsigned BTN_CNT    = 1;
  localparam int unsigned BTN_UPDATE = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_STOP   = 4;
  localparam int unsigned NUM_BTN    = 5;

  function automatic regime_e mode_from_press(input logic elist, input logic cnt,
                                              input logic update);
    if (update)     return REGIME_UPDATE;
    else if (cnt)   return REGIME_CNT;
    else if (elist) return REGIME_ELIST;
    else            return REGIME_OFF;
  endfunction

endpackage

// File: rtl/mode_input_ctrl_if.sv
// mode_input_ctrl_if
// Handshake between the operator-input front end and the control path.
//   regime      : current mode reported by the control path
//   active      : control-path ELIST sequence running
//   on          : mode request towards the control path (0 = none)
//   start       : start level towards the control path
//   busy        : front end not idle
//   err_timeout : one-cycle pulse when a request is abandoned
// master = front end, slave = control path.
interface mode_input_ctrl_if;
  logic [1:0] regime;
  logic       active;
  logic [1:0] on;
  logic       start;
  logic       busy;
  logic       err_timeout;

  modport master (input regime, active, output on, start, busy, err_timeout);
  modport slave  (output regime, active, input on, start, busy, err_timeout);
endinterface

// File: rtl/mode_input_ctrl_btn_debounce.sv
// btn_debounce
// One push-button: optional 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the debounced rising edge (releases are silent).
// Build option: INPUT_SYNC_EN adds the 2-flop synchronizer in front.
// Ports: clk, rst (sync, active-high), raw (button), press (pulse out).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sample;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

`ifdef INPUT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  end

  assign sample = sync_q[1];
`else
  assign sample = raw;
`endif

  // Counter tracks consecutive samples that disagree with the debounced
  // level; the pulse is registered on the same edge as the level flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sample != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sample;
          cnt_q   <= '0;
          press_q <= sample;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/mode_input_ctrl.sv
// mode_input_ctrl
// Operator-input front end: debounces five buttons, turns mode presses into
// a held request on ctl.on, handshakes on ctl.regime / ctl.active and drives
// the start level. All outputs are registered.
// Ports: clk, rst (sync, active-high), btn_elist, btn_cnt, btn_update,
//        btn_start, btn_stop (raw buttons), ctl (handshake, master side).
// Build option: INPUT_SYNC_EN (2-flop synchronizer on each button).
module mode_input_ctrl
  import mode_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REQ_TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_elist,
  input  logic                  btn_cnt,
  input  logic                  btn_update,
  input  logic                  btn_start,
  input  logic                  btn_stop,
  mode_input_ctrl_if.master     ctl
);

  localparam int unsigned TW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(REQ_TIMEOUT - 1);

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] press;

  assign raw_btn = {btn_stop, btn_start, btn_update, btn_cnt, btn_elist};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_btn[i]),
      .press (press[i])
    );
  end

  state_e        state_q, state_d;
  regime_e       req_q, req_d;
  regime_e       mode_sel;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    on_q, on_d;
  logic          start_q, start_d;
  logic          busy_q;
  logic          err_q, err_d;
  logic          active_q;
  logic          active_rise;

  assign mode_sel    = mode_from_press(press[BTN_ELIST], press[BTN_CNT], press[BTN_UPDATE]);
  assign active_rise = ctl.active & ~active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= REGIME_OFF;
      tmo_q    <= '0;
      on_q     <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      tmo_q    <= tmo_d;
      on_q     <= on_d;
      start_q  <= start_d;
      busy_q   <= (state_d != IDLE);
      err_q    <= err_d;
      active_q <= ctl.active;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tmo_d   = tmo_q;
    on_d    = on_q;
    start_d = start_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        on_d    = '0;
        start_d = 1'b0;
        // Stop in the same cycle suppresses any mode press.
        if (!press[BTN_STOP] && (mode_sel != REGIME_OFF)) begin
          req_d   = mode_sel;
          tmo_d   = '0;
          on_d    = mode_sel;
          state_d = REQ;
        end
      end

      REQ: begin
        // A match beats both an abort and a timeout in the same cycle.
        if (ctl.regime == req_q) begin
          on_d    = '0;
          state_d = RUN;
        end else if (press[BTN_STOP]) begin
          on_d    = '0;
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          on_d    = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RUN: begin
        on_d = '0;
        if (ctl.regime == REGIME_OFF) begin
          start_d = 1'b0;
          state_d = IDLE;
        end else begin
          case (req_q)
            REGIME_CNT: begin
              if (press[BTN_STOP])       start_d = 1'b0;
              else if (press[BTN_START]) start_d = ~start_q;
            end
            REGIME_ELIST: begin
              // Single trigger: the control path picking it up ends it.
              if (press[BTN_STOP] || active_rise) start_d = 1'b0;
              else if (press[BTN_START])          start_d = 1'b1;
            end
            default: start_d = 1'b0;
          endcase
        end
      end

      default: begin
        on_d    = '0;
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ctl.on          = on_q;
  assign ctl.start       = start_q;
  assign ctl.busy        = busy_q;
  assign ctl.err_timeout = err_q;

endmodule
